divider32: RTL

Sequential 32-bit unsigned divider that is the inverse of the existing Adder32 datapath. It produces quotient and remainder by restoring shift-subtract, one quotient bit per clock. Each trial subtraction uses one Adder32 instance, wired as operand1 + ~divisor + 1. It sits beside Adder32 in the ALU experiments and uses a start/busy/done handshake so a controller or bench can drive it.

---
 rtl/divider32.sv | 112 +++++++++++
 1 files changed

// File: rtl/divider32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Each trial subtraction reuses the Adder32 datapath as a + ~b + 1.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module divider32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] divisor;
    logic [31:0] qreg;
    // Bit 32 of the partial remainder is always zero between iterations
    // (a restore only happens when shifted[32]=0), so only 32 bits are kept.
    logic [31:0] prem;
    logic [4:0]  count;

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        cout;
    logic        ge;
    logic [31:0] prem_nxt;
    logic [31:0] qreg_nxt;
    logic        accept;

    assign shifted = {prem, qreg[31]};

    adder32 u_sub (
        .a   (shifted[31:0]),
        .b   (~divisor),
        .cin (1'b1),
        .sum (diff),
        .cout(cout)
    );

    assign ge       = shifted[32] | cout;
    assign prem_nxt = ge ? diff : shifted[31:0];
    assign qreg_nxt = {qreg[30:0], ge};
    assign accept   = start && (state != RUN);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)              state_nxt = (operand2 == 32'd0) ? DONE : RUN;
                else if (state == DONE)  state_nxt = IDLE;
            end
            RUN: begin
                if (count == 5'd31) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor     <= 32'd0;
            qreg        <= 32'd0;
            prem        <= 32'd0;
            count       <= 5'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (operand2 == 32'd0) begin
                quotient    <= 32'hFFFF_FFFF;
                remainder   <= operand1;
                div_by_zero <= 1'b1;
            end else begin
                divisor <= operand2;
                qreg    <= operand1;
                prem    <= 32'd0;
                count   <= 5'd0;
            end
        end else if (state == RUN) begin
            qreg  <= qreg_nxt;
            prem  <= prem_nxt;
            count <= count + 5'd1;
            if (count == 5'd31) begin
                quotient    <= qreg_nxt;
                remainder   <= prem_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule
